// File: rtl/cpu_instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel and the
// instruction handoff channel toward execute. The fetch block is the master.
interface cpu_instr_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, instr_valid, instr_data, instr_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready
  );
endinterface

// File: rtl/cpu_instr_fetch.sv
// Instruction fetch stage: one outstanding memory read per sequencer FETCH,
// instruction handed to execute over valid/ready, PC owned here with redirect.
// Optional response timeout: define FETCH_TIMEOUT_EN to enable the WAIT
// watchdog and the sticky fetch_err flag; otherwise fetch_err is constant 0.
module cpu_instr_fetch #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int ADDR_STEP   = 4,
  parameter int RESET_PC    = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpu_state,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic              busy,
  output logic              fetch_err,
  cpu_instr_fetch_if.master bus
);
  localparam logic [ADDR_W-1:0] PC0  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
  localparam logic [1:0]        CPU_FETCH = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} st_t;

  st_t               state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, ra, ra_n, ip, ip_n;
  logic [DATA_W-1:0] id, id_n;
  logic              disc, disc_n, rv, rv_n, iv, iv_n, bsy;
  logic              to_hit;

  assign bus.mem_req_valid = rv;
  assign bus.mem_req_addr  = ra;
  assign bus.instr_valid   = iv;
  assign bus.instr_data    = id;
  assign bus.instr_pc      = ip;
  assign busy              = bsy;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
  logic             err;

  assign to_hit    = (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign fetch_err = err;

  // WAIT-cycle counter restarts on every entry to WAIT; error flag is sticky
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (state == S_WAIT) ? cnt + 1'b1 : '0;
      if (state == S_WAIT && !bus.mem_rsp_valid && to_hit) err <= 1'b1;
    end
  end
`else
  // keeps the timeout parameter referenced in builds without the watchdog
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYC;
  assign to_hit    = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // next state and next register values; pc_load is evaluated first so it wins
  always_comb begin
    state_n = state;
    pc_n    = pc;
    disc_n  = disc;
    rv_n    = rv;
    ra_n    = ra;
    iv_n    = iv;
    id_n    = id;
    ip_n    = ip;
    case (state)
      S_IDLE: begin
        if (pc_load) begin
          pc_n = pc_load_value;
        end else if (cpu_state == CPU_FETCH) begin
          state_n = S_REQ;
          rv_n    = 1'b1;
          ra_n    = pc;
        end
      end
      S_REQ: begin
        // request is never withdrawn; a redirect only marks its data stale
        if (pc_load) begin
          pc_n   = pc_load_value;
          disc_n = 1'b1;
        end
        if (bus.mem_req_ready) begin
          state_n = S_WAIT;
          rv_n    = 1'b0;
        end
      end
      S_WAIT: begin
        if (pc_load) begin
          pc_n   = pc_load_value;
          disc_n = 1'b1;
        end
        if (bus.mem_rsp_valid) begin
          if (pc_load || disc) begin
            disc_n  = 1'b0;
            state_n = S_IDLE;
          end else begin
            id_n    = bus.mem_rsp_data;
            ip_n    = pc;
            pc_n    = pc + STEP;
            iv_n    = 1'b1;
            state_n = S_HOLD;
          end
        end else if (to_hit) begin
          disc_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      S_HOLD: begin
        if (pc_load) begin
          pc_n    = pc_load_value;
          iv_n    = 1'b0;
          state_n = S_IDLE;
        end else if (bus.instr_ready) begin
          iv_n    = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // state, PC and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= PC0;
      disc  <= 1'b0;
      rv    <= 1'b0;
      ra    <= PC0;
      iv    <= 1'b0;
      id    <= '0;
      ip    <= '0;
      bsy   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      disc  <= disc_n;
      rv    <= rv_n;
      ra    <= ra_n;
      iv    <= iv_n;
      id    <= id_n;
      ip    <= ip_n;
      bsy   <= (state_n != S_IDLE);
    end
  end
endmodule

// File: tb/tb_cpu_instr_fetch.sv
// Self-checking bench for cpu_instr_fetch: a memory responder, a negedge
// monitor with a scoreboard of expected {pc, data}, and directed scenarios.
module tb_cpu_instr_fetch;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO_CYC = 255;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    cpu_state;
  logic          pc_load;
  logic [AW-1:0] pc_load_value;
  logic          busy, fetch_err;

  cpu_instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cpu_instr_fetch #(
    .ADDR_W(AW), .DATA_W(DW), .ADDR_STEP(4), .RESET_PC(0), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .reset(reset), .cpu_state(cpu_state), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .busy(busy), .fetch_err(fetch_err), .bus(bus)
  );

  always #5 clk = ~clk;

  int   nchk = 0, nerr = 0;
  int   hs_cnt = 0, ins_cnt = 0;
  logic [AW-1:0] hs_addr = '0;
  ent_t sb[$];
  int   rsp_lat = 0;
  bit   rsp_block = 0, rsp_ovr = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    return (a == '0) ? 32'hDEADBEEF : {~a, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int maxc);
    int n = 0;
    while (!bus.mem_req_valid && n < maxc) begin tick(); n++; end
    chk("req_seen", bus.mem_req_valid, 1);
  endtask

  task automatic wait_instr(input int maxc);
    int n = 0;
    while (!bus.instr_valid && n < maxc) begin tick(); n++; end
    chk("instr_seen", bus.instr_valid, 1);
  endtask

  task automatic wait_cons(input int k, input int maxc);
    int n = 0;
    int tgt = ins_cnt + k;
    while (ins_cnt < tgt && n < maxc) begin tick(); n++; end
    chk("cons_seen", ins_cnt >= tgt, 1);
  endtask

  task automatic drain();
    int n = 0;
    cpu_state = 2'b00;
    bus.mem_req_ready = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    while ((busy || bus.instr_valid || bus.mem_req_valid) && n < 50) begin tick(); n++; end
    chk("drain_idle", busy, 0);
  endtask

  // monitor: inputs and outputs seen at negedge are what the next posedge uses
  initial begin : mon
    ent_t e;
    logic [AW-1:0] exp_addr, req_lat;
    logic req_prev, outst;
    exp_addr = '0; req_lat = '0; req_prev = 1'b0; outst = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        exp_addr = '0;
        req_prev = 1'b0;
        outst    = 1'b0;
      end else begin
        if (bus.mem_rsp_valid) outst = 1'b0;
        if (bus.mem_req_valid) begin
          if (!req_prev) begin
            chk("req_addr", bus.mem_req_addr, exp_addr);
            req_lat = bus.mem_req_addr;
          end else begin
            chk("req_stable", bus.mem_req_addr, req_lat);
          end
          if (bus.mem_req_ready) begin
            chk("one_outst", outst, 0);
            outst   = 1'b1;
            hs_addr = bus.mem_req_addr;
            hs_cnt++;
            sb.push_back('{pc: bus.mem_req_addr, data: memval(bus.mem_req_addr)});
          end
        end
        req_prev = bus.mem_req_valid && !bus.mem_req_ready;
        if (bus.instr_valid) begin
          chk("instr_has_exp", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            chk("instr_pc", bus.instr_pc, sb[0].pc);
            chk("instr_data", bus.instr_data, sb[0].data);
            if (bus.instr_ready && !pc_load) begin
              e = sb.pop_front();
              exp_addr = e.pc + 16'd4;
              ins_cnt++;
            end
          end
        end
        if (pc_load) begin
          exp_addr = pc_load_value;
          sb.delete();
        end
      end
    end
  end

  // memory responder: one response per accepted request, rsp_lat cycles late
  initial begin : rsp
    int last = 0, wait_n = 0;
    bit arm = 0;
    logic [AW-1:0] a = '0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    forever begin
      tick();
      bus.mem_rsp_valid = 1'b0;
      if (hs_cnt != last) begin
        last = hs_cnt; arm = 1; wait_n = rsp_lat; a = hs_addr;
      end
      if (arm) begin
        if (wait_n == 0) begin
          arm = 0;
          if (!rsp_block) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = rsp_ovr ? 32'h11111111 : memval(a);
          end
        end else begin
          wait_n--;
        end
      end
    end
  end

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    int n, h0;
    logic [DW-1:0] d;
    logic [AW-1:0] p;
    reset = 1'b1; cpu_state = 2'b00; pc_load = 1'b0; pc_load_value = '0;
    bus.mem_req_ready = 1'b0; bus.instr_ready = 1'b0;
    tick(); tick();
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_req_addr", bus.mem_req_addr, 0);
    chk("rst_iv", bus.instr_valid, 0);
    chk("rst_idata", bus.instr_data, 0);
    chk("rst_ipc", bus.instr_pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", fetch_err, 0);
    reset = 1'b0;
    tick();

    // basic fetch, then two more back to back
    cpu_state = 2'b10; bus.mem_req_ready = 1'b1; bus.instr_ready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.instr_valid && n < 20);
    chk("t1_latency", n, 3);
    chk("t1_pc", bus.instr_pc, 0);
    chk("t1_data", bus.instr_data, 32'hDEADBEEF);
    wait_req(20);
    chk("t1_next_addr", bus.mem_req_addr, 16'h0004);
    wait_cons(2, 40);
    drain();

    // backpressure on both channels
    bus.mem_req_ready = 1'b0; bus.instr_ready = 1'b0; h0 = hs_cnt;
    cpu_state = 2'b10;
    wait_req(10);
    cpu_state = 2'b00;
    repeat (5) tick();
    chk("t2_req_hold", bus.mem_req_valid, 1);
    bus.mem_req_ready = 1'b1;
    wait_instr(10);
    bus.mem_req_ready = 1'b0;
    d = bus.instr_data; p = bus.instr_pc;
    repeat (4) tick();
    chk("t2_iv_hold", bus.instr_valid, 1);
    chk("t2_data_hold", bus.instr_data, d);
    chk("t2_pc_hold", bus.instr_pc, p);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("t2_iv_drop", bus.instr_valid, 0);
    chk("t2_one_req", hs_cnt - h0, 1);
    drain();

    // redirect in WAIT one cycle before the response
    rsp_lat = 2; rsp_ovr = 1; cpu_state = 2'b10;
    wait_req(10);
    tick();
    chk("t3_in_wait", bus.mem_req_valid, 0);
    tick();
    pc_load = 1'b1; pc_load_value = 16'h0100;
    tick();
    pc_load = 1'b0;
    wait_req(20);
    chk("t3_addr", bus.mem_req_addr, 16'h0100);
    rsp_ovr = 0; rsp_lat = 0;
    wait_cons(1, 20);
    drain();

    // redirect and consume in the same HOLD cycle
    bus.instr_ready = 1'b0; cpu_state = 2'b10;
    wait_instr(20);
    pc_load = 1'b1; pc_load_value = 16'h0200; bus.instr_ready = 1'b1;
    tick();
    pc_load = 1'b0; bus.instr_ready = 1'b0;
    chk("t4_iv", bus.instr_valid, 0);
    wait_req(10);
    chk("t4_addr", bus.mem_req_addr, 16'h0200);
    bus.instr_ready = 1'b1;
    wait_cons(1, 20);
    drain();

    // PC wrap-around
    pc_load = 1'b1; pc_load_value = 16'hFFFC;
    tick();
    pc_load = 1'b0; cpu_state = 2'b10;
    wait_instr(20);
    chk("t5_pc", bus.instr_pc, 16'hFFFC);
    wait_req(20);
    chk("t5_wrap", bus.mem_req_addr, 16'h0000);
    drain();

`ifdef FETCH_TIMEOUT_EN
    rsp_block = 1; bus.mem_req_ready = 1'b1; cpu_state = 2'b10;
    wait_req(10);
    p = bus.mem_req_addr;
    tick();
    bus.mem_req_ready = 1'b0;
    n = 0;
    while (!fetch_err && n < 300) begin tick(); n++; end
    chk("t6_err", fetch_err, 1);
    chk("t6_cycles", n, TO_CYC);
    chk("t6_idle", busy, 0);
    wait_req(10);
    chk("t6_pc_kept", bus.mem_req_addr, p);
`else
    cpu_state = 2'b10; bus.mem_req_ready = 1'b0;
    wait_req(10);
    chk("t6_no_err", fetch_err, 0);
`endif

    // asynchronous reset while a request is pending
    chk("t7_busy_pre", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("t7_req_valid", bus.mem_req_valid, 0);
    chk("t7_req_addr", bus.mem_req_addr, 0);
    chk("t7_iv", bus.instr_valid, 0);
    chk("t7_idata", bus.instr_data, 0);
    chk("t7_ipc", bus.instr_pc, 0);
    chk("t7_busy", busy, 0);
    chk("t7_err", fetch_err, 0);
    tick();
    reset = 1'b0; rsp_block = 0; rsp_lat = 0;
    bus.mem_req_ready = 1'b1; bus.instr_ready = 1'b1;
    wait_req(10);
    chk("t7_restart_addr", bus.mem_req_addr, 0);
    wait_cons(1, 20);
    drain();

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/cpu_instr_fetch.md
Name: cpu_instr_fetch

Overview:
- Fetch stage beside the CPU sequencing FSM (2-bit state: 00 INIT, 01 LOAD_REGISTERS, 10 FETCH, 11 EXECUTE).
- While the sequencer is in FETCH, this block issues one instruction-memory read at the current PC over a valid/ready request channel and captures the response.
- It presents the instruction and its PC to the execute side over a valid/ready handshake, then advances the PC.
- It owns the program counter, including redirect/branch load.

Parameters:
- ADDR_W, 16, PC and memory address width
- DATA_W, 32, instruction width
- ADDR_STEP, 4, PC increment per fetched instruction (modulo 2^ADDR_W)
- RESET_PC, 0, PC value after reset
- TIMEOUT_CYC, 255, response timeout in cycles (only with FETCH_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_state  in  2  sequencer state; 2'b10 = FETCH
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  read address (= PC)
- mem_rsp_valid  in  1  read data valid, one per accepted request
- mem_rsp_data  in  DATA_W  read data
- instr_valid  out  1  instruction available
- instr_ready  in  1  execute side consumes instruction
- instr_data  out  DATA_W  fetched instruction
- instr_pc  out  ADDR_W  address it was fetched from
- pc_load  in  1  redirect strobe
- pc_load_value  in  ADDR_W  redirect target
- busy  out  1  high in REQ, WAIT or HOLD
- fetch_err  out  1  timeout flag (FETCH_TIMEOUT_EN only)

Behaviour:
- Reset state (asynchronous):
  - FSM = IDLE, pc = RESET_PC, discard flag = 0.
  - mem_req_valid = 0, mem_req_addr = RESET_PC.
  - instr_valid = 0, instr_data = 0, instr_pc = 0, busy = 0, fetch_err = 0.
- FSM states: IDLE, REQ, WAIT, HOLD. All outputs are registered.
- IDLE:
  - If cpu_state == 2'b10 and pc_load == 0: go to REQ, with mem_req_valid = 1 and mem_req_addr = pc from the next cycle.
  - Other cpu_state values: remain in IDLE.
- REQ:
  - mem_req_valid and mem_req_addr stay stable until mem_req_ready is sampled high.
  - On the handshake cycle (valid & ready): go to WAIT; mem_req_valid = 0 next cycle.
  - cpu_state leaving FETCH does not withdraw the request.
- WAIT:
  - On mem_req_rsp, i.e. mem_rsp_valid high with discard = 0: instr_data <= mem_rsp_data, instr_pc <= pc, pc <= pc + ADDR_STEP, go to HOLD with instr_valid = 1.
  - With discard = 1: drop the data, clear discard, go to IDLE.
  - The earliest response is the cycle after the request handshake. Fetch latency is therefore at least 3 cycles from the FETCH trigger to instr_valid.
- HOLD:
  - instr_valid = 1; instr_data and instr_pc hold stable until instr_ready.
  - On instr_ready: go to IDLE, instr_valid = 0 next cycle.
- pc_load (takes priority over every other event in the same cycle):
  - IDLE: pc <= pc_load_value; no fetch starts that cycle.
  - REQ: pc <= pc_load_value and discard <= 1. The request stays asserted until accepted (no withdrawal), and its response is then dropped.
  - WAIT: pc <= pc_load_value, discard <= 1. If mem_rsp_valid arrives in the same cycle, it is dropped and the FSM goes to IDLE.
  - HOLD: pc <= pc_load_value, instr_valid <= 0, go to IDLE. The instruction is dropped even if instr_ready is high in the same cycle.
- PC arithmetic: unsigned, wraps modulo 2^ADDR_W (e.g. 16'hFFFC + 4 = 16'h0000).
- Exactly one outstanding request at a time. An mem_rsp_valid arriving in IDLE, REQ or HOLD is ignored.
- Reset mid-transaction returns to the reset state immediately; any in-flight response after reset is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN
- With it:
  - A counter runs in WAIT. If TIMEOUT_CYC cycles elapse without mem_rsp_valid, fetch_err is set (sticky until reset) and the FSM returns to IDLE.
  - The PC is unchanged.
  - A response arriving later is ignored.
- Without it: no counter, fetch_err is tied to 0, and WAIT waits indefinitely.

Test Plan:
1. Basic fetch:
   - Stimulus: reset, then cpu_state = 10, mem_req_ready = 1. Response 32'hDEADBEEF arrives the cycle after the handshake; instr_ready = 1.
   - Required: mem_req_addr = 0; instr_valid with instr_data = DEADBEEF, instr_pc = 0; next request at addr 4.
2. Backpressure:
   - Stimulus: mem_req_ready low for 5 cycles, then instr_ready low for 4 cycles.
   - Required: mem_req_valid and mem_req_addr stable throughout; instr_valid, instr_data and instr_pc stable until instr_ready; only one request issued.
3. Redirect in WAIT:
   - Stimulus: pc_load = 1, pc_load_value = 16'h0100 one cycle before a response of 32'h11111111.
   - Required: no instr_valid; the next fetch uses mem_req_addr = 0100.
4. Redirect/consume collision in HOLD:
   - Stimulus: pc_load (16'h0200) and instr_ready high in the same cycle.
   - Required: instr_valid = 0 next cycle; the next request is at 0200.
5. Wrap-around:
   - Stimulus: pc_load_value = 16'hFFFC, then a fetch.
   - Required: instr_pc = FFFC; the following request is at 0000.
6. Timeout and reset (FETCH_TIMEOUT_EN):
   - Stimulus: no response for 255 cycles.
   - Required: fetch_err = 1, FSM back in IDLE, pc unchanged.
   - Then assert reset mid-REQ. Required: all outputs return to reset values asynchronously.
